pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch controller that owns the program counter for the single-cycle core and sequences the instruction ROM.
- Starts execution on command and advances PC each cycle.
- Handles stall, branch/jump redirect, halt/resume and end-of-program detection; keeps a retired-instruction count.
- Sits between core control (branch unit, hazard logic, debug/host) and the instruction ROM address input.

Parameters:
- PC_W, 8, PC/ROM address width.
- PROG_LEN, 13, number of valid ROM words; legal PC range 0..PROG_LEN-1.
- RESET_PC, 0, PC value loaded at reset and on every (re)start.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  begin (IDLE/DONE) or resume (HALT) execution.
- halt_req  in  1  request to pause after the current cycle.
- stall  in  1  hold PC; current instruction not retired.
- branch_taken  in  1  redirect PC this cycle.
- branch_target  in  PC_W  redirect destination.
- pc  out  PC_W  ROM address (registered).
- instr_valid  out  1  instruction at pc retires this cycle.
- running  out  1  state==RUN.
- done  out  1  program finished (registered).
- fault  out  1  illegal branch target seen (registered, sticky until start).
- retired_cnt  out  CNT_W  retired instructions since last start, saturating.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, pc=RESET_PC, done=0, fault=0, retired_cnt=0. instr_valid=0 and running=0 follow from state.
- States: IDLE, RUN, HALT, DONE (2-bit encoding, 0..3).
- IDLE:
  - start -> RUN.
  - pc stays RESET_PC; first instruction retires in the first RUN cycle (1-cycle start latency).
- RUN: instr_valid = !stall (combinational). Priority at each posedge:
  1. halt_req -> HALT. Current instruction still retires if !stall. pc advances or redirects as below, so resume continues at the next instruction.
  2. stall -> pc held, no retire. branch_taken is ignored while stall=1.
  3. branch_taken with branch_target < PROG_LEN -> pc=branch_target.
  4. branch_taken with branch_target >= PROG_LEN -> DONE, fault=1, pc held.
  5. pc==PROG_LEN-1, no branch -> DONE, done=1, pc held at PROG_LEN-1.
  6. Otherwise pc=pc+1.
- Branch on the last instruction to a legal target is taken; no DONE.
- PC never wraps and never exceeds PROG_LEN-1.
- retired_cnt increments on every instr_valid cycle and saturates at all-ones.
- HALT:
  - pc and retired_cnt held; instr_valid=0.
  - start -> RUN.
  - halt_req ignored.
- DONE:
  - pc held; done and fault held.
  - start -> RUN with pc=RESET_PC, done=0, fault=0, retired_cnt=0.
- start while in RUN is ignored.
- Reset mid-operation has priority over all inputs; state returns to IDLE in the same edge.
- All outputs except instr_valid and running are registered.

Optional Feature:
- Macro: PC_SEQ_SINGLE_STEP_EN.
- With the macro:
  - Extra input step (1 bit).
  - In HALT, step (with start=0) retires exactly one instruction: for one cycle the block behaves as RUN, instr_valid=1, normal pc update rules apply, then it returns to HALT. It goes to DONE instead if the step ends the program.
  - If start and step are both asserted, start wins.
  - Added state STEP (encoding 4); the state register widens to 3 bits.
- Without the macro: no step port, four states, 2-bit state register.

Decomposition:
- Package pc_seq_pkg:
  - state enum (IDLE, RUN, HALT, DONE, STEP).
  - default parameter constants PC_W_DEF, PROG_LEN_DEF, RESET_PC_DEF.
- One sub-module, pc_next_calc: combinational next-PC, retire and terminate decode from state, stall, branch and pc.
- Top level holds the state register, pc, flags and counter.

Test Plan:
- Reset, then start held one cycle -> pc sequences 0,1,...,12 with instr_valid=1 each cycle; then done=1, pc=12, retired_cnt=13, running=0.
- Stall held at pc=3 for 2 cycles -> pc stays 3, instr_valid=0, retired_cnt unchanged; pc=4 one cycle after stall drops.
- branch_taken, target=9 at pc=2 -> next pc=9; target=20 -> DONE, fault=1, pc unchanged.
- halt_req at pc=5 -> instruction 5 retires, pc=6, state HALT; start -> pc 6 retires next cycle.
- rst=0 at pc=7 during RUN -> next edge: IDLE, pc=0, counters and flags clear; start from DONE -> restart at pc=0.
- (PC_SEQ_SINGLE_STEP_EN) In HALT at pc=4, pulse step three times -> pc 5,6,7, retired_cnt +3, HALT after each.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared state encoding and default sizing for the fetch PC sequencer.
// PC_SEQ_SINGLE_STEP_EN adds the STEP state and widens the state register to 3 bits.
package pc_seq_pkg;

   localparam int PC_W_DEF     = 8;
   localparam int PROG_LEN_DEF = 13;
   localparam int RESET_PC_DEF = 0;
   localparam int CNT_W_DEF    = 16;

`ifdef PC_SEQ_SINGLE_STEP_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_HALT = 3'd2,
      S_DONE = 3'd3,
      S_STEP = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_DONE = 2'd3
   } state_t;
`endif

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC, retire and termination decode (zero latency).
// Stall suppresses retire, branch and end detection; PC never exceeds PROG_LEN-1.
module pc_next_calc
   import pc_seq_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int PROG_LEN = PROG_LEN_DEF
) (
   input  state_t          i_state,
   input  logic            i_stall,
   input  logic            i_branch_taken,
   input  logic [PC_W-1:0] i_branch_target,
   input  logic [PC_W-1:0] i_pc,
   output logic [PC_W-1:0] o_pc_next,
   output logic            o_retire,
   output logic            o_bad_target,
   output logic            o_last
);

   localparam logic [PC_W:0]   LP_LEN  = (PC_W+1)'(PROG_LEN);
   localparam logic [PC_W-1:0] LP_LAST = PC_W'(PROG_LEN - 1);

   logic w_active;
   logic w_exec;
   logic w_tgt_ok;
   logic w_at_last;

`ifdef PC_SEQ_SINGLE_STEP_EN
   assign w_active = (i_state == S_RUN) || (i_state == S_STEP);
`else
   assign w_active = (i_state == S_RUN);
`endif

   assign w_exec    = w_active && !i_stall;
   assign w_tgt_ok  = {1'b0, i_branch_target} < LP_LEN;
   assign w_at_last = (i_pc == LP_LAST);
   assign o_retire  = w_exec;

   // An illegal target or a fall-through off the last word both hold the PC.
   always_comb begin
      o_pc_next    = i_pc;
      o_bad_target = 1'b0;
      o_last       = 1'b0;
      if (w_exec) begin
         if (i_branch_taken) begin
            if (w_tgt_ok) begin
               o_pc_next = i_branch_target;
            end else begin
               o_bad_target = 1'b1;
            end
         end else if (w_at_last) begin
            o_last = 1'b1;
         end else begin
            o_pc_next = i_pc + PC_W'(1);
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller owning the ROM PC: 1-cycle start latency, stall holds PC without retiring.
// PC_SEQ_SINGLE_STEP_EN adds an i_step input that retires one instruction from HALT.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int PROG_LEN = PROG_LEN_DEF,
   parameter int RESET_PC = RESET_PC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_halt_req,
   input  logic             i_stall,
   input  logic             i_branch_taken,
   input  logic [PC_W-1:0]  i_branch_target,
`ifdef PC_SEQ_SINGLE_STEP_EN
   input  logic             i_step,
`endif
   output logic [PC_W-1:0]  o_pc,
   output logic             o_instr_valid,
   output logic             o_running,
   output logic             o_done,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_retired_cnt
);

   localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

   state_t            r_state;
   state_t            w_state_next;
   logic [PC_W-1:0]   r_pc;
   logic              r_done;
   logic              r_fault;
   logic [CNT_W-1:0]  r_cnt;

   logic [PC_W-1:0]   w_pc_next;
   logic              w_retire;
   logic              w_bad;
   logic              w_last;
   logic              w_restart;
   logic              w_halting;

   pc_next_calc #(
      .PC_W     (PC_W),
      .PROG_LEN (PROG_LEN)
   ) u_next_calc (
      .i_state         (r_state),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_pc            (r_pc),
      .o_pc_next       (w_pc_next),
      .o_retire        (w_retire),
      .o_bad_target    (w_bad),
      .o_last          (w_last)
   );

   assign w_restart = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // A halt request outranks termination: the PC is held and the block parks in HALT.
   assign w_halting = (r_state == S_RUN) && i_halt_req;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (i_start) w_state_next = S_RUN;
         S_RUN: begin
            if (i_halt_req)            w_state_next = S_HALT;
            else if (w_bad || w_last)  w_state_next = S_DONE;
         end
         S_HALT: begin
            if (i_start)               w_state_next = S_RUN;
`ifdef PC_SEQ_SINGLE_STEP_EN
            else if (i_step)           w_state_next = S_STEP;
`endif
         end
         S_DONE: if (i_start) w_state_next = S_RUN;
`ifdef PC_SEQ_SINGLE_STEP_EN
         S_STEP: begin
            if (w_bad || w_last)       w_state_next = S_DONE;
            else if (w_retire)         w_state_next = S_HALT;
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_pc    <= LP_RESET_PC;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_restart) begin
            r_pc    <= LP_RESET_PC;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_pc <= w_pc_next;
            if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last && !w_halting) r_done  <= 1'b1;
            if (w_bad && !w_halting)  r_fault <= 1'b1;
         end
      end
   end

   assign o_pc          = r_pc;
   assign o_instr_valid = w_retire;
   assign o_running     = (r_state == S_RUN);
   assign o_done        = r_done;
   assign o_fault       = r_fault;
   assign o_retired_cnt = r_cnt;

endmodule
